green_interpolation: RTL and testbench

- Green-channel reconstruction at a red/blue site of a 12-bit Bayer CFA image.
- Computes gradient-corrected horizontal and vertical green estimates from a 5-point cross (radius 2).
- Mixes the two estimates with a spatial-score weight and a frequency-score weight, then blends those two results by the H/V disagreement.
- Sits after the gradient/score stage and before red/blue interpolation in the CFA pipeline.

---
 rtl/cfa_pkg.sv | 19 +
 rtl/green_dir_est.sv | 43 ++++
 rtl/green_interpolation.sv | 170 +++++++++++++++++
 tb/tb_green_interpolation.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
//==============================================================================
// Module      : cfa_pkg
// Description : Shared CFA pipeline constants and the pixel type.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cfa_pkg;

    localparam int PIX_W    = 12;
    localparam int WGT_ONE  = 128;
    localparam int WGT_HALF = 64;
    localparam int PIX_MAX  = 4095;

    typedef logic [PIX_W-1:0] pix_t;

endpackage : cfa_pkg

`default_nettype wire

// File: rtl/green_dir_est.sv
//==============================================================================
// Module      : green_dir_est
// Description : Gradient-corrected directional green estimate from five taps,
//               clamped to the pixel range.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module green_dir_est
    import cfa_pkg::*;
(
    input  pix_t        i_m2,
    input  pix_t        i_m1,
    input  pix_t        i_c,
    input  pix_t        i_p1,
    input  pix_t        i_p2,
    output logic [13:0] o_est
);

    logic [15:0]        w_pos;
    logic [15:0]        w_neg;
    logic signed [15:0] w_raw;
    logic signed [15:0] w_shr;

    // 16 bits hold the full positive range (up to 6*4095) without wrapping
    assign w_pos = ({4'd0, i_m1} + {4'd0, i_p1} + {4'd0, i_c}) << 1;
    assign w_neg = {4'd0, i_m2} + {4'd0, i_p2};
    assign w_raw = $signed(w_pos) - $signed(w_neg);
    assign w_shr = w_raw >>> 2;

    always_comb begin
        if (w_shr < 16'sd0) begin
            o_est = '0;
        end else if (w_shr > $signed(16'(PIX_MAX))) begin
            o_est = 14'(PIX_MAX);
        end else begin
            o_est = w_shr[13:0];
        end
    end

endmodule : green_dir_est

`default_nettype wire

// File: rtl/green_interpolation.sv
//==============================================================================
// Module      : green_interpolation
// Description : Three-stage green reconstruction at an R/B Bayer site.
//               Optional macro GREEN_INTP_DBG_EN adds aligned debug outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module green_interpolation
    import cfa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  pix_t        p_m2_p0,
    input  pix_t        p_m1_p0,
    input  pix_t        p_p1_p0,
    input  pix_t        p_p2_p0,
    input  pix_t        p_p0_m2,
    input  pix_t        p_p0_m1,
    input  pix_t        p_p0_p1,
    input  pix_t        p_p0_p2,
    input  pix_t        p_p0_p0,
    input  logic [7:0]  scaled_hs,
    input  logic [7:0]  scaled_vs,
    input  logic [7:0]  w_grad_hf,
    input  logic [7:0]  w_grad_vf,
    input  logic [7:0]  spatial_th,
    input  logic [7:0]  freq_th,
    input  logic [8:0]  blend_th0,
    input  logic [8:0]  blend_th1,
    output pix_t        green
`ifdef GREEN_INTP_DBG_EN
    ,
    output logic [13:0] dbg_gh,
    output logic [13:0] dbg_gv,
    output logic [12:0] dbg_diff,
    output logic [12:0] dbg_gs,
    output logic [12:0] dbg_gf
`endif
);

    function automatic logic [7:0] weight_sel(input logic [7:0] h, input logic [7:0] v,
                                              input logic [7:0] th);
        logic [7:0] d;
        d = (h >= v) ? (h - v) : (v - h);
        if (d <= th)     return 8'(WGT_HALF);
        else if (h < v)  return 8'(WGT_ONE);
        else             return 8'd0;
    endfunction

    // Q7 mix with round-half-up; result never exceeds the larger operand
    function automatic logic [12:0] q7_blend(input logic [7:0] w, input logic [12:0] a,
                                             input logic [12:0] b);
        logic [20:0] acc;
        acc = 21'(w) * 21'(a) + 21'(8'(WGT_ONE) - w) * 21'(b) + 21'(WGT_HALF);
        return 13'(acc >> 7);
    endfunction

    logic [13:0] w_gh, w_gv;
    logic [13:0] r_gh, r_gv;
    logic [7:0]  r_ws, r_wf;
    logic [8:0]  r_th0_s1, r_th1_s1;
    logic [12:0] w_diff;
    logic [12:0] r_diff, r_gs, r_gf;
    logic [8:0]  r_th0_s2, r_th1_s2;
    logic [7:0]  w_alpha;
    logic [12:0] w_out;

    green_dir_est u_est_h (
        .i_m2  (p_p0_m2),
        .i_m1  (p_p0_m1),
        .i_c   (p_p0_p0),
        .i_p1  (p_p0_p1),
        .i_p2  (p_p0_p2),
        .o_est (w_gh)
    );

    green_dir_est u_est_v (
        .i_m2  (p_m2_p0),
        .i_m1  (p_m1_p0),
        .i_c   (p_p0_p0),
        .i_p1  (p_p1_p0),
        .i_p2  (p_p2_p0),
        .o_est (w_gv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gh     <= '0;
            r_gv     <= '0;
            r_ws     <= '0;
            r_wf     <= '0;
            r_th0_s1 <= '0;
            r_th1_s1 <= '0;
        end else begin
            r_gh     <= w_gh;
            r_gv     <= w_gv;
            r_ws     <= weight_sel(scaled_hs, scaled_vs, spatial_th);
            r_wf     <= weight_sel(w_grad_hf, w_grad_vf, freq_th);
            r_th0_s1 <= blend_th0;
            r_th1_s1 <= blend_th1;
        end
    end

    // Both estimates are clamped to 12 bits, so the 13-bit difference is exact
    assign w_diff = (r_gh >= r_gv) ? (r_gh[12:0] - r_gv[12:0]) : (r_gv[12:0] - r_gh[12:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff   <= '0;
            r_gs     <= '0;
            r_gf     <= '0;
            r_th0_s2 <= '0;
            r_th1_s2 <= '0;
        end else begin
            r_diff   <= w_diff;
            r_gs     <= q7_blend(r_ws, r_gh[12:0], r_gv[12:0]);
            r_gf     <= q7_blend(r_wf, r_gh[12:0], r_gv[12:0]);
            r_th0_s2 <= r_th0_s1;
            r_th1_s2 <= r_th1_s1;
        end
    end

    // Low-threshold test first so th0 >= th1 resolves to the spatial result
    always_comb begin
        w_alpha = 8'(WGT_HALF);
        if (r_diff <= {4'd0, r_th0_s2}) begin
            w_alpha = 8'd0;
        end else if (r_diff >= {4'd0, r_th1_s2}) begin
            w_alpha = 8'(WGT_ONE);
        end
    end

    assign w_out = q7_blend(w_alpha, r_gf, r_gs);

    always_ff @(posedge clk) begin
        if (rst) begin
            green <= '0;
        end else begin
            green <= (w_out > 13'(PIX_MAX)) ? pix_t'(PIX_MAX) : w_out[11:0];
        end
    end

`ifdef GREEN_INTP_DBG_EN
    logic [13:0] r_gh_s2, r_gv_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gh_s2  <= '0;
            r_gv_s2  <= '0;
            dbg_gh   <= '0;
            dbg_gv   <= '0;
            dbg_diff <= '0;
            dbg_gs   <= '0;
            dbg_gf   <= '0;
        end else begin
            r_gh_s2  <= r_gh;
            r_gv_s2  <= r_gv;
            dbg_gh   <= r_gh_s2;
            dbg_gv   <= r_gv_s2;
            dbg_diff <= r_diff;
            dbg_gs   <= r_gs;
            dbg_gf   <= r_gf;
        end
    end
`endif

endmodule : green_interpolation

`default_nettype wire

// File: tb/tb_green_interpolation.sv
//==============================================================================
// Module      : tb_green_interpolation
// Description : Scoreboard bench for green_interpolation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_green_interpolation;

    typedef struct {
        int v_m2, v_m1, v_p1, v_p2;
        int h_m2, h_m1, h_p1, h_p2;
        int c;
        int hs, vs, hf, vf, sth, fth, th0, th1;
    } vec_t;

    typedef struct {
        string tag;
        int    exp;
        int    due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] p_m2_p0 = '0, p_m1_p0 = '0, p_p1_p0 = '0, p_p2_p0 = '0;
    logic [11:0] p_p0_m2 = '0, p_p0_m1 = '0, p_p0_p1 = '0, p_p0_p2 = '0, p_p0_p0 = '0;
    logic [7:0]  scaled_hs = '0, scaled_vs = '0, w_grad_hf = '0, w_grad_vf = '0;
    logic [7:0]  spatial_th = '0, freq_th = '0;
    logic [8:0]  blend_th0 = '0, blend_th1 = '0;
    logic [11:0] green;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_edges  = 0;
    exp_t sb[$];

    green_interpolation dut (
        .clk        (clk),
        .rst        (rst),
        .p_m2_p0    (p_m2_p0),
        .p_m1_p0    (p_m1_p0),
        .p_p1_p0    (p_p1_p0),
        .p_p2_p0    (p_p2_p0),
        .p_p0_m2    (p_p0_m2),
        .p_p0_m1    (p_p0_m1),
        .p_p0_p1    (p_p0_p1),
        .p_p0_p2    (p_p0_p2),
        .p_p0_p0    (p_p0_p0),
        .scaled_hs  (scaled_hs),
        .scaled_vs  (scaled_vs),
        .w_grad_hf  (w_grad_hf),
        .w_grad_vf  (w_grad_vf),
        .spatial_th (spatial_th),
        .freq_th    (freq_th),
        .blend_th0  (blend_th0),
        .blend_th1  (blend_th1),
        .green      (green)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int est(int m2, int m1, int c, int p1, int p2);
        int r;
        r = (2 * (m1 + p1) + 2 * c - m2 - p2) >>> 2;
        if (r < 0) r = 0;
        if (r > 4095) r = 4095;
        return r;
    endfunction

    function automatic int wsel(int h, int v, int th);
        int d;
        d = (h > v) ? h - v : v - h;
        if (d <= th) return 64;
        return (h < v) ? 128 : 0;
    endfunction

    function automatic int mix(int w, int a, int b);
        return (w * a + (128 - w) * b + 64) / 128;
    endfunction

    function automatic int model(vec_t v);
        int gh, gv, diff, gs, gf, alpha, o;
        gh = est(v.h_m2, v.h_m1, v.c, v.h_p1, v.h_p2);
        gv = est(v.v_m2, v.v_m1, v.c, v.v_p1, v.v_p2);
        diff = (gh > gv) ? gh - gv : gv - gh;
        gs = mix(wsel(v.hs, v.vs, v.sth), gh, gv);
        gf = mix(wsel(v.hf, v.vf, v.fth), gh, gv);
        if (diff <= v.th0)      alpha = 0;
        else if (diff >= v.th1) alpha = 128;
        else                    alpha = 64;
        o = mix(alpha, gf, gs);
        return (o > 4095) ? 4095 : o;
    endfunction

    function automatic vec_t mk(int vm2, int vm1, int vp1, int vp2, int hm2, int hm1,
                                int hp1, int hp2, int c);
        vec_t v;
        v.v_m2 = vm2; v.v_m1 = vm1; v.v_p1 = vp1; v.v_p2 = vp2;
        v.h_m2 = hm2; v.h_m1 = hm1; v.h_p1 = hp1; v.h_p2 = hp2; v.c = c;
        v.hs = 10; v.vs = 100; v.sth = 20; v.hf = 50; v.vf = 50; v.fth = 5;
        v.th0 = 100; v.th1 = 400;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v.v_m2 = $urandom_range(4095); v.v_m1 = $urandom_range(4095);
        v.v_p1 = $urandom_range(4095); v.v_p2 = $urandom_range(4095);
        v.h_m2 = $urandom_range(4095); v.h_m1 = $urandom_range(4095);
        v.h_p1 = $urandom_range(4095); v.h_p2 = $urandom_range(4095);
        v.c    = $urandom_range(4095);
        v.hs = $urandom_range(255); v.vs = $urandom_range(255);
        v.hf = $urandom_range(255); v.vf = $urandom_range(255);
        v.sth = $urandom_range(60); v.fth = $urandom_range(60);
        v.th0 = $urandom_range(300); v.th1 = $urandom_range(511);
        return v;
    endfunction

    task automatic set_inputs(input vec_t v);
        p_m2_p0 = 12'(v.v_m2); p_m1_p0 = 12'(v.v_m1);
        p_p1_p0 = 12'(v.v_p1); p_p2_p0 = 12'(v.v_p2);
        p_p0_m2 = 12'(v.h_m2); p_p0_m1 = 12'(v.h_m1);
        p_p0_p1 = 12'(v.h_p1); p_p0_p2 = 12'(v.h_p2);
        p_p0_p0 = 12'(v.c);
        scaled_hs = 8'(v.hs); scaled_vs = 8'(v.vs);
        w_grad_hf = 8'(v.hf); w_grad_vf = 8'(v.vf);
        spatial_th = 8'(v.sth); freq_th = 8'(v.fth);
        blend_th0 = 9'(v.th0); blend_th1 = 9'(v.th1);
    endtask

    task automatic drive(input string tag, input vec_t v);
        @(negedge clk);
        set_inputs(v);
        sb.push_back('{tag, model(v), n_edges + 3});
    endtask

    // Reset for one edge while junk sits on the inputs; the pipeline must flush to zero
    task automatic apply_reset(input vec_t junk, input string tag, input vec_t next);
        @(negedge clk);
        rst = 1'b1;
        set_inputs(junk);
        sb.delete();
        for (int k = 1; k <= 3; k++) sb.push_back('{"reset_zero", 0, n_edges + k});
        @(negedge clk);
        rst = 1'b0;
        set_inputs(next);
        sb.push_back('{tag, model(next), n_edges + 3});
    endtask

    always @(posedge clk) begin
        #1;
        n_edges = n_edges + 1;
        if (sb.size() > 0 && sb[0].due == n_edges) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, int'(green), e.exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t flat, hedge, mid, lo, hi, degen, v;
        flat  = mk(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000);
        flat.hs = 77; flat.vs = 3; flat.th0 = 17; flat.th1 = 250;
        hedge = mk(1000, 500, 500, 1000, 1000, 2000, 2000, 1000, 1000);
        mid   = mk(1000, 1000, 1000, 1000, 1000, 1200, 1200, 1000, 1000);
        lo    = mk(4095, 0, 0, 4095, 4095, 0, 0, 4095, 0);
        hi    = mk(0, 4095, 4095, 0, 0, 4095, 4095, 0, 4095);
        degen = mid;
        degen.th0 = 300; degen.th1 = 100;

        apply_reset(hi, "flat", flat);
        check("model_hedge", model(hedge), 1250);
        check("model_mid", model(mid), 1150);
        drive("hedge", hedge);
        drive("mid", mid);
        drive("clamp_low", lo);
        drive("clamp_high", hi);
        drive("degen_th", degen);

        for (int i = 0; i < 2; i++) drive("thru_pre", rnd_vec());
        v = rnd_vec();
        apply_reset(hi, "thru_post0", v);
        for (int i = 0; i < 3; i++) drive("thru_post", rnd_vec());

        for (int i = 0; i < 12; i++) drive("random", rnd_vec());

        repeat (6) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_green_interpolation

`default_nettype wire
